// File: rtl/chunk_readback_serializer.sv
// chunk_readback_serializer
//   Return path from the CFD compute fabric to the host. A BLOCK_SIZE-bit result
//   chunk is captured, then emitted as WPB 16-bit words, least-significant word
//   first, each packed as {frame_last, addr[14:0], data[15:0]}. NUM_BLOCKS chunks
//   form one frame; addr runs contiguously across the frame and wraps to 0 after
//   the frame's last word.
//
// Ports
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous active-high reset
//   chunk_din_i    result chunk from the compute fabric
//   chunk_valid_i  chunk_din_i valid
//   chunk_ready_o  a chunk can be captured this cycle (IDLE)
//   word_dout_o    [31] frame_last, [30:16] addr, [15:0] data
//   word_valid_o   word_dout_o valid (EMIT)
//   word_ready_i   host consumes word_dout_o this cycle
//   frame_done_o   one-cycle pulse after the frame's last word is accepted
//   busy_o         high while in EMIT

module chunk_readback_serializer #(
    parameter int unsigned NUM_BLOCKS = 3,
    parameter int unsigned BLOCK_SIZE = 2500
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BLOCK_SIZE-1:0] chunk_din_i,
    input  logic                  chunk_valid_i,
    output logic                  chunk_ready_o,
    output logic [31:0]           word_dout_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic                  frame_done_o,
    output logic                  busy_o
);

    localparam int unsigned WordW = 16;
    localparam int unsigned Wpb   = (BLOCK_SIZE + WordW - 1) / WordW;
    localparam int unsigned SrW   = Wpb * WordW;
    localparam int unsigned IdxW  = (Wpb > 1) ? $clog2(Wpb) : 1;
    localparam int unsigned BlkW  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } state_e;

    state_e            state_q;
    logic [SrW-1:0]    shreg_q;
    logic [IdxW-1:0]   word_idx_q;
    logic [BlkW-1:0]   block_num_q;
    logic [14:0]       addr_q;
    logic              frame_done_q;

    logic last_word;
    logic last_block;

    assign last_word  = (word_idx_q == IdxW'(Wpb - 1));
    assign last_block = (block_num_q == BlkW'(NUM_BLOCKS - 1));

    // addr_q tracks block_num*Wpb + word_idx incrementally; it only wraps at frame end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            word_idx_q   <= '0;
            block_num_q  <= '0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (chunk_valid_i) begin
                        // Zero-extends the chunk to a whole number of words.
                        shreg_q <= SrW'(chunk_din_i);
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    // chunk_valid_i is deliberately ignored here: single buffer.
                    if (word_ready_i) begin
                        shreg_q <= shreg_q >> WordW;
                        if (last_word) begin
                            word_idx_q <= '0;
                            state_q    <= StIdle;
                            if (last_block) begin
                                block_num_q  <= '0;
                                addr_q       <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                block_num_q <= block_num_q + BlkW'(1);
                                addr_q      <= addr_q + 15'd1;
                            end
                        end else begin
                            word_idx_q <= word_idx_q + IdxW'(1);
                            addr_q     <= addr_q + 15'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // All outputs come straight from registers or the state; nothing depends on
    // word_ready_i combinationally.
    assign chunk_ready_o = (state_q == StIdle);
    assign word_valid_o  = (state_q == StEmit);
    assign busy_o        = (state_q == StEmit);
    assign frame_done_o  = frame_done_q;
    assign word_dout_o   = {last_block & last_word, addr_q, shreg_q[WordW-1:0]};

endmodule

// File: tb/tb_chunk_readback_serializer.sv
module tb_chunk_readback_serializer;

    localparam int BS  = 2500;
    localparam int WPB = 157;

    logic          clk = 1'b0;
    logic          rst;
    logic [BS-1:0] chunk_din;
    logic          chunk_valid;
    logic          chunk_ready;
    logic [31:0]   word_dout;
    logic          word_valid;
    logic          word_ready;
    logic          frame_done;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [BS-1:0] exp_chunk;
    int            exp_block;
    logic [31:0]   got [WPB];

    always #5 clk = ~clk;

    chunk_readback_serializer #(
        .NUM_BLOCKS(3),
        .BLOCK_SIZE(BS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .chunk_din_i  (chunk_din),
        .chunk_valid_i(chunk_valid),
        .chunk_ready_o(chunk_ready),
        .word_dout_o  (word_dout),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
        .frame_done_o (frame_done),
        .busy_o       (busy)
    );

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] fill;
        logic [3:0]  top;
        bit          rnd;
        bit          exp_fd;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e156;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BS-1:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                         input logic [15:0] fill, input logic [3:0] top);
        logic [WPB*16-1:0] p;
        for (int k = 0; k < WPB; k++) p[16*k +: 16] = fill;
        p[15:0]   = w0;
        p[31:16]  = w1;
        p[2511:2496] = {12'h000, top};
        return p[BS-1:0];
    endfunction

    // Called just after a clock edge; returns just after the capture edge.
    task automatic send_chunk(input logic [BS-1:0] c, input bit hold);
        int w = 0;
        while (!chunk_ready && w < 400) begin
            @(posedge clk); #1; w++;
        end
        check("chunk_ready before capture", 32'(chunk_ready), 32'd1);
        chunk_din   = c;
        chunk_valid = 1'b1;
        exp_chunk   = c;
        @(posedge clk); #1;
        if (!hold) chunk_valid = 1'b0;
        check("word_valid after capture", 32'(word_valid), 32'd1);
        check("busy in emit", 32'(busy), 32'd1);
        check("chunk_ready in emit", 32'(chunk_ready), 32'd0);
        check("frame_done in emit", 32'(frame_done), 32'd0);
    endtask

    task automatic collect(input int nwords, input bit rnd, input bit fin, input bit exp_fd);
        int                n      = 0;
        int                cyc    = 0;
        int                fd_cnt = 0;
        bit                stalled = 1'b0;
        logic [31:0]       prev   = '0;
        logic [31:0]       expw;
        logic              flag;
        logic [WPB*16-1:0] pad;
        pad = {12'h000, exp_chunk};
        while (n < nwords && cyc < 4000) begin
            if (frame_done) fd_cnt++;
            if (stalled) begin
                check("stall dout hold", word_dout, prev);
                check("stall valid hold", 32'(word_valid), 32'd1);
            end
            word_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled    = word_valid && !word_ready;
            prev       = word_dout;
            if (word_valid && word_ready) begin
                flag = (exp_block == 2) && (n == WPB - 1);
                expw = {flag, 15'(exp_block * WPB + n), pad[16*n +: 16]};
                check($sformatf("word %0d blk %0d", n, exp_block), word_dout, expw);
                got[n] = word_dout;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        word_ready = 1'b0;
        check("transfer count", 32'(n), 32'(nwords));
        if (!rnd) check("back-to-back cycles", 32'(cyc), 32'(nwords));
        check("no frame_done inside chunk", 32'(fd_cnt), 32'd0);
        if (fin) begin
            check("frame_done after last", 32'(frame_done), 32'(exp_fd));
            check("idle word_valid", 32'(word_valid), 32'd0);
            check("idle chunk_ready", 32'(chunk_ready), 32'd1);
            check("idle busy", 32'(busy), 32'd0);
            exp_block = exp_fd ? 0 : exp_block + 1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BS-1:0] ca;
        logic [BS-1:0] cb;

        vecs[0] = '{16'hA5A5, 16'h1234, 16'h0000, 4'hF, 1'b0, 1'b0,
                    32'h0000_A5A5, 32'h0001_1234, 32'h009C_000F};
        vecs[1] = '{16'hBEEF, 16'h0001, 16'h0001, 4'h3, 1'b1, 1'b0,
                    32'h009D_BEEF, 32'h009E_0001, 32'h0139_0003};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0002, 4'hA, 1'b0, 1'b1,
                    32'h013A_0000, 32'h013B_FFFF, 32'h81D6_000A};
        vecs[3] = '{16'h5A5A, 16'hC3C3, 16'h0003, 4'h1, 1'b1, 1'b0,
                    32'h0000_5A5A, 32'h0001_C3C3, 32'h009C_0001};

        rst         = 1'b1;
        chunk_din   = '0;
        chunk_valid = 1'b0;
        word_ready  = 1'b0;
        exp_block   = 0;
        exp_chunk   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset word_valid", 32'(word_valid), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset chunk_ready", 32'(chunk_ready), 32'd1);
        check("reset word_dout", word_dout, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vectors 0..2 form one full frame, vector 3 restarts the frame.
        for (int v = 0; v < 4; v++) begin
            send_chunk(mk(vecs[v].w0, vecs[v].w1, vecs[v].fill, vecs[v].top), 1'b0);
            collect(WPB, vecs[v].rnd, 1'b1, vecs[v].exp_fd);
            check($sformatf("vec %0d word0", v), got[0], vecs[v].e0);
            check($sformatf("vec %0d word1", v), got[1], vecs[v].e1);
            check($sformatf("vec %0d word156", v), got[WPB-1], vecs[v].e156);
        end

        // Reset after the 50th word of chunk 1 of the frame.
        send_chunk(mk(16'h7777, 16'h7777, 16'h7777, 4'h7), 1'b0);
        collect(50, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post-reset word_valid", 32'(word_valid), 32'd0);
        check("post-reset chunk_ready", 32'(chunk_ready), 32'd1);
        check("post-reset busy", 32'(busy), 32'd0);
        exp_block = 0;
        send_chunk(mk(16'h1111, 16'h2222, 16'h1111, 4'h9), 1'b0);
        collect(WPB, 1'b0, 1'b1, 1'b0);
        check("post-reset first addr", 32'(got[0][30:16]), 32'd0);

        // chunk_valid held through EMIT while chunk_din changes.
        ca = mk(16'hAAAA, 16'hABCD, 16'hAAAA, 4'h2);
        cb = mk(16'h5555, 16'h4321, 16'h5555, 4'h6);
        send_chunk(ca, 1'b1);
        chunk_din = cb;
        collect(WPB, 1'b1, 1'b1, 1'b0);
        check("held: word0 from first chunk", got[0], 32'h009D_AAAA);
        exp_chunk = cb;
        @(posedge clk); #1;
        chunk_valid = 1'b0;
        check("held: recapture after idle", 32'(word_valid), 32'd1);
        collect(WPB, 1'b0, 1'b1, 1'b1);
        check("held: second chunk word0", got[0], 32'h013A_5555);
        @(posedge clk); #1;
        check("frame_done single pulse", 32'(frame_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
